// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Purpose  : Sequencer for the multi-cycle HI/LO divide (DIV / DIVU) issued
//             from the execute stage. Drives a radix-2 restoring
//             shift-subtract datapath, one quotient bit per clock. It raises
//             the pipeline divide stall and returns {remainder, quotient}.
//             It also handles divide-by-zero, signed correction and E-stage
//             flush (annul).
//
//  Ports    : clk       rising-edge clock
//             rst       synchronous, active-high reset
//             start     divide instruction present in E stage (held while
//                       the pipeline is stalled)
//             sign      1 = DIV (signed), 0 = DIVU
//             opa       dividend (rs), WIDTH bits
//             opb       divisor  (rt), WIDTH bits
//             annul     E-stage flush; aborts any operation in flight
//             divstart  stall request to the hazard unit (combinational)
//             ready     result valid this cycle
//             result    {remainder (HI), quotient (LO)}, 2*WIDTH bits
//             divzero   current result came from a zero divisor
//
//  Options  : `define DIV_EARLY_TERM_EN to finish in one cycle when
//             |opa| < |opb|. The result is then {opa, 0}. Without the
//             macro, every non-zero divide runs all WIDTH iterations.
//
//  Revision : 1.0  initial release
// ============================================================================
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sign,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 annul,
    output logic                 divstart,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 divzero
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DZERO = 2'd1;
    localparam logic [1:0] c_ON    = 2'd2;
    localparam logic [1:0] c_END   = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_rem;       // partial remainder
    logic [WIDTH-1:0]     r_quo;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]     r_dvsr;      // divisor magnitude
    logic                 r_sa;        // dividend was negative (signed op only)
    logic                 r_sb;        // divisor was negative (signed op only)
    logic                 r_sgn;       // operation is signed
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_divzero;

    // ------------------------------------------------------------------------
    // Operand conditioning (issue cycle)
    // ------------------------------------------------------------------------
    logic                 w_opb_zero;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_early;

    assign w_opb_zero = (opb == '0);
    assign w_neg_a    = sign & opa[WIDTH-1];
    assign w_neg_b    = sign & opb[WIDTH-1];
    // The most negative value negates to itself. Read as unsigned, that is
    // still the correct magnitude.
    assign w_abs_a    = w_neg_a ? -opa : opa;
    assign w_abs_b    = w_neg_b ? -opb : opb;

`ifdef DIV_EARLY_TERM_EN
    // Quotient is zero and remainder is the raw dividend; no iterations needed.
    assign w_early = (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // One restoring iteration
    // ------------------------------------------------------------------------
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_trial;
    logic                 w_borrow;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_quo_fix;

    // The partial remainder is always below the divisor. So the shifted
    // remainder is below 2*divisor, and WIDTH+1 bits hold the trial
    // difference. When the trial goes negative, its top bit is set.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvsr};
    assign w_borrow  = w_trial[WIDTH];
    assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

    // Sign correction on the final iteration's values. The quotient follows
    // the XOR of the operand signs. The remainder follows the dividend.
    assign w_quo_fix = (r_sgn & (r_sa ^ r_sb)) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = (r_sgn & r_sa)          ? -w_rem_nxt : w_rem_nxt;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (annul) begin
            // Flush wins over everything except reset.
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_opb_zero) begin
                            w_state_nxt = c_DZERO;
                        end else if (w_early) begin
                            w_state_nxt = c_END;
                        end else begin
                            w_state_nxt = c_ON;
                        end
                    end
                end
                c_DZERO: begin
                    w_state_nxt = c_END;
                end
                c_ON: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_END;
                    end
                end
                c_END: begin
                    // Stay while the pipeline still presents the same divide,
                    // so it is not issued twice.
                    if (!start) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        divstart = 1'b0;
        ready    = 1'b0;
        // Combinational so that the stall already covers the issue cycle.
        divstart = start & ~annul & (r_state != c_END);
        ready    = (r_state == c_END);
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_sgn     <= 1'b0;
            r_result  <= '0;
            r_divzero <= 1'b0;
        end else if (!annul) begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_opb_zero) begin
                            // Park the raw dividend. It becomes the HI value.
                            r_rem <= opa;
                        end else if (w_early) begin
                            r_result  <= {opa, {WIDTH{1'b0}}};
                            r_divzero <= 1'b0;
                        end else begin
                            r_rem  <= '0;
                            r_quo  <= w_abs_a;
                            r_dvsr <= w_abs_b;
                            r_sa   <= w_neg_a;
                            r_sb   <= w_neg_b;
                            r_sgn  <= sign;
                            r_cnt  <= '0;
                        end
                    end
                end
                c_DZERO: begin
                    // No sign correction for a zero divisor.
                    r_result  <= {r_rem, {WIDTH{1'b1}}};
                    r_divzero <= 1'b1;
                end
                c_ON: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result  <= {w_rem_fix, w_quo_fix};
                        r_divzero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result  = r_result;
    assign divzero = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Purpose  : Self-checking bench for div_ctrl (WIDTH = 32). Directed cases
//             are checked against known constants. Random cases are checked
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        divstart;
    logic        ready;
    logic [63:0] result;
    logic        divzero;

    int n_tests;
    int n_fail;
    logic [63:0] last_exp;   // result expected to be held by the DUT

    div_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .opa      (opa),
        .opb      (opb),
        .annul    (annul),
        .divstart (divstart),
        .ready    (ready),
        .result   (result),
        .divzero  (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? -x : x;
    endfunction

    // Truncating division: quotient rounds toward zero, remainder takes the
    // sign of the dividend. A zero divisor gives {dividend, all ones}.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [31:0] q;
        logic [31:0] r;
        logic        na;
        logic        nb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        na = s & a[31];
        nb = s & b[31];
        q  = mag(a, s) / mag(b, s);
        r  = mag(a, s) % mag(b, s);
        if (na ^ nb) q = -q;
        if (na)      r = -r;
        return {r, q};
    endfunction

    // Cycles from issue to the first ready cycle.
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_TERM_EN
        if (mag(a, s) < mag(b, s)) return 1;
`endif
        return 33;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------------
    // Issue a divide and hold start until ready (bounded). Returns at the
    // negedge of the first ready cycle with start still high.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output int stall, output logic ds_rdy);
        @(posedge clk); #1;
        start = 1'b1; sign = s; opa = a; opb = b;
        lat = 0; stall = 0;
        @(negedge clk);
        while (ready !== 1'b1 && lat < 100) begin
            if (divstart === 1'b1) stall++;
            @(negedge clk);
            lat++;
        end
        ds_rdy = divstart;
    endtask

    task automatic release_start;
        start = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0; annul = 1'b0; sign = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_tests++; if (divstart !== 1'b0) begin n_fail++; $display("FAIL reset_divstart: got %b expected 0", divstart); end
        n_tests++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_tests++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero: got %b expected 0", divzero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat, stall; logic ds;
        do_div(32'd100, 32'd7, 1'b0, lat, stall, ds);
        n_tests++; if (lat != 33) begin n_fail++; $display("FAIL u100_7_latency: got %0d expected 33", lat); end
        n_tests++; if (stall != 33) begin n_fail++; $display("FAIL u100_7_stall: got %0d expected 33", stall); end
        n_tests++; if (ds !== 1'b0) begin n_fail++; $display("FAIL u100_7_divstart_at_ready: got %b expected 0", ds); end
        n_tests++; if (result !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL u100_7_result: got %h expected 000000020000000e", result); end
        n_tests++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL u100_7_divzero: got %b expected 0", divzero); end
        release_start();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL u100_7_idle_after: got %b expected 0", ready); end
    endtask

    task automatic test_signed;
        int lat, stall; logic ds;
        do_div(-32'sd7, 32'd2, 1'b1, lat, stall, ds);
        n_tests++; if (result !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL s_m7_2_result: got %h expected fffffffffffffffd", result); end
        n_tests++; if (lat != 33) begin n_fail++; $display("FAIL s_m7_2_latency: got %0d expected 33", lat); end
        release_start();
        do_div(32'd7, -32'sd2, 1'b1, lat, stall, ds);
        n_tests++; if (result !== 64'h00000001_FFFFFFFD) begin n_fail++; $display("FAIL s_7_m2_result: got %h expected 00000001fffffffd", result); end
        release_start();
    endtask

    task automatic test_divzero;
        int lat, stall; logic ds;
        do_div(32'h12345678, 32'd0, 1'b1, lat, stall, ds);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL dz_latency: got %0d expected 2", lat); end
        n_tests++; if (stall != 2) begin n_fail++; $display("FAIL dz_stall: got %0d expected 2", stall); end
        n_tests++; if (divzero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", divzero); end
        n_tests++; if (result !== 64'h12345678_FFFFFFFF) begin n_fail++; $display("FAIL dz_result: got %h expected 12345678ffffffff", result); end
        release_start();
    endtask

    task automatic test_overflow;
        int lat, stall; logic ds;
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, stall, ds);
        n_tests++; if (lat != 33) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
        n_tests++; if (result !== 64'h00000000_80000000) begin n_fail++; $display("FAIL ovf_result: got %h expected 0000000080000000", result); end
        n_tests++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL ovf_divzero: got %b expected 0", divzero); end
        last_exp = 64'h00000000_80000000;
        release_start();
    endtask

    task automatic test_annul;
        int lat, stall; logic ds; logic seen;
        @(posedge clk); #1;
        start = 1'b1; sign = 1'b0; opa = 32'd100; opb = 32'd7;
        @(negedge clk);                 // issue cycle T
        repeat (10) @(negedge clk);     // T+10, tenth ON cycle
        annul = 1'b1;
        #1;
        n_tests++; if (divstart !== 1'b0) begin n_fail++; $display("FAIL annul_divstart: got %b expected 0", divstart); end
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL annul_ready_next: got %b expected 0", ready); end
        start = 1'b0; annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL annul_ready_seen: got %b expected 0", seen); end
        n_tests++; if (result !== last_exp) begin n_fail++; $display("FAIL annul_result_held: got %h expected %h", result, last_exp); end
        do_div(32'd9, 32'd3, 1'b0, lat, stall, ds);
        n_tests++; if (result !== 64'h00000000_00000003) begin n_fail++; $display("FAIL annul_then_9_3: got %h expected 0000000000000003", result); end
        n_tests++; if (lat != 33) begin n_fail++; $display("FAIL annul_then_9_3_latency: got %0d expected 33", lat); end
        release_start();
    endtask

    task automatic test_hold;
        int lat, stall; logic ds;
        do_div(32'd1000, 32'd10, 1'b0, lat, stall, ds);
        n_tests++; if (result !== 64'h00000000_00000064) begin n_fail++; $display("FAIL hold_result: got %h expected 0000000000000064", result); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_%0d: got %b expected 1", i, ready); end
            n_tests++; if (divstart !== 1'b0) begin n_fail++; $display("FAIL hold_divstart_%0d: got %b expected 0", i, divstart); end
        end
        n_tests++; if (result !== 64'h00000000_00000064) begin n_fail++; $display("FAIL hold_result_stable: got %h expected 0000000000000064", result); end
        release_start();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL hold_idle_after: got %b expected 0", ready); end
        last_exp = 64'h00000000_00000064;
    endtask

    task automatic test_early;
        int lat, stall; logic ds; int el;
        el = exp_lat(32'd5, 32'd9, 1'b0);
        do_div(32'd5, 32'd9, 1'b0, lat, stall, ds);
        n_tests++; if (result !== 64'h00000005_00000000) begin n_fail++; $display("FAIL early_5_9_result: got %h expected 0000000500000000", result); end
        n_tests++; if (lat != el) begin n_fail++; $display("FAIL early_5_9_latency: got %0d expected %0d", lat, el); end
        n_tests++; if (stall != el) begin n_fail++; $display("FAIL early_5_9_stall: got %0d expected %0d", stall, el); end
        release_start();
    endtask

    task automatic test_back_to_back;
        int lat, stall; logic ds;
        do_div(32'd81, 32'd9, 1'b0, lat, stall, ds);
        n_tests++; if (result !== 64'h00000000_00000009) begin n_fail++; $display("FAIL b2b_81_9: got %h expected 0000000000000009", result); end
        release_start();
        do_div(32'hFFFFFFFF, 32'd3, 1'b0, lat, stall, ds);
        n_tests++; if (result !== 64'h00000000_55555555) begin n_fail++; $display("FAIL b2b_ffffffff_3: got %h expected 0000000055555555", result); end
        release_start();
        do_div(-32'sd100, -32'sd7, 1'b1, lat, stall, ds);
        n_tests++; if (result !== 64'hFFFFFFFE_0000000E) begin n_fail++; $display("FAIL b2b_m100_m7: got %h expected fffffffe0000000e", result); end
        release_start();
    endtask

    task automatic test_random;
        int lat, stall; logic ds;
        logic [31:0] a, b; logic s; logic [63:0] exp_r; int el; int mode;
        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 5));
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'($urandom_range(0, 1000));
                    b = 32'($urandom_range(1001, 100000));
                end
                default: b = $urandom;
            endcase
            exp_r = model(a, b, s);
            el    = exp_lat(a, b, s);
            do_div(a, b, s, lat, stall, ds);
            n_tests++; if (result !== exp_r) begin n_fail++; $display("FAIL rand_%0d_result (%h/%h s=%b): got %h expected %h", i, a, b, s, result, exp_r); end
            n_tests++; if (lat != el) begin n_fail++; $display("FAIL rand_%0d_latency: got %0d expected %0d", i, lat, el); end
            n_tests++; if (divzero !== (b == 32'd0)) begin n_fail++; $display("FAIL rand_%0d_divzero: got %b expected %b", i, divzero, (b == 32'd0)); end
            release_start();
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(posedge clk); #1;
        start = 1'b1; sign = 1'b1; opa = 32'd12345; opb = 32'd11;
        repeat (6) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
        n_tests++; if (result !== 64'd0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", result); end
        n_tests++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL rstmid_divzero: got %b expected 0", divzero); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_seen: got %b expected 0", seen); end
    endtask

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_exp = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_overflow();
        test_annul();
        test_hold();
        test_early();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer for the multi-cycle HI/LO divide (DIV/DIVU) issued from the execute stage. Runs a radix-2 restoring shift-subtract datapath.
- Drives the pipeline divide stall (`divstart`) consumed by the hazard unit, and returns a 64-bit {remainder, quotient} for the HI/LO write path.
- Handles divide-by-zero, signed correction and pipeline flush (annul).

Parameters:
- WIDTH, 32, operand width; quotient and remainder each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  divide instruction present in E stage; held high while stalled
- sign  in  1  1 = DIV (signed), 0 = DIVU
- opa  in  WIDTH  dividend (rs)
- opb  in  WIDTH  divisor (rt)
- annul  in  1  flush of E stage; abort any operation
- divstart  out  1  stall request to hazard unit
- ready  out  1  result valid this cycle
- result  out  2*WIDTH  {remainder (HI), quotient (LO)}
- divzero  out  1  current result came from a zero divisor

Behaviour:
- States: IDLE, DZERO, ON, END. Counter cnt is $clog2(WIDTH)+1 bits.
- Reset:
  - state=IDLE, cnt=0; result, ready, divzero = 0. divstart=0 (combinational, state-derived).
- divstart = start & ~annul & (state != END). Combinational, so the stall begins in the issue cycle.
- IDLE:
  - start & ~annul & opb==0 -> DZERO.
  - start & ~annul & opb!=0 -> ON. Latches |opa|, |opb| (absolute only if sign), sign flags of opa, opb, and sign. Partial remainder=0, cnt=0.
  - Otherwise stays IDLE.
- DZERO, one cycle -> END:
  - result = {opa, {WIDTH{1'b1}}}, i.e. remainder = dividend, quotient = all ones.
  - divzero=1. No sign correction applied.
- ON, one iteration per cycle:
  - Shift {rem, quo} left 1; trial = rem_shifted - divisor.
  - If trial is non-negative: rem = trial, quo[0] = 1; else quo[0] = 0.
  - cnt += 1. When cnt reaches WIDTH-1 during the cycle, next state is END.
  - The END entry applies sign correction and registers the result:
    - quotient negated if sign & (sa ^ sb);
    - remainder negated if sign & sa.
- END:
  - ready=1 for every cycle in END; result stable.
  - -> IDLE when start==0. While start stays high, remains END with divstart=0, so the pipeline advances and the operation is not restarted.
- Latency: issue in cycle T (IDLE), ON in T+1..T+WIDTH, ready in T+WIDTH+1. Stall cycles = WIDTH+1. Divide-by-zero: ready at T+2.
- annul:
  - Highest priority after rst; in any state, next state = IDLE, ready deasserted next cycle.
  - divstart forced 0 in the same cycle; result not updated.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (natural wrap). No trap.
- result holds its last value until the next END entry.
- rst mid-operation: same as the reset values; no partial result is exposed.
- Arithmetic is WIDTH+1 bits for the trial subtraction; the borrow bit selects the quotient bit.

Optional Feature:
- DIV_EARLY_TERM_EN
- Defined:
  - In IDLE, if opb!=0 and |opa| < |opb| (unsigned compare of the absolute values), go straight to END.
  - result = {opa, 0}; ready at T+1; divstart high only in cycle T.
- Undefined: every non-zero divide takes the full WIDTH+1 stall cycles.

Test Plan:
- Unsigned 100 / 7, start held until ready:
  - ready at T+33; result = {0x00000002, 0x0000000E}; divstart high T..T+32, low at T+33.
- Signed -7 / 2:
  - result = {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3).
  - Signed 7 / -2 gives {0x00000001, 0xFFFFFFFD}.
- Divide by zero, opa = 0x12345678, opb = 0:
  - ready at T+2, divzero=1, result = {0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF -> result = {0x00000000, 0x80000000}, no hang.
- annul at the 10th ON cycle:
  - divstart=0 that cycle; state IDLE next cycle; ready never asserted; result unchanged.
  - A new 9/3 issued afterwards returns {0, 3}.
- start held 3 cycles past END:
  - ready stays 1 and divstart stays 0 for those cycles, no restart; IDLE after start drops.
  - With DIV_EARLY_TERM_EN, 5/9 unsigned gives ready at T+1, result {5, 0}.
